// File: rtl/screen_scanout_if.sv
// Pixel stream from screen_scanout to a serial sink: valid/ready handshake
// carrying one coverage bit plus its coordinates and end-of-line/frame marks.
interface screen_scanout_if #(
  parameter int XW = 2,
  parameter int YW = 2
) ();
  logic          pix_valid;
  logic          pix_ready;
  logic          pix_data;
  logic [XW-1:0] pix_x;
  logic [YW-1:0] pix_y;
  logic          line_end;
  logic          frame_end;

  modport master (
    output pix_valid, pix_data, pix_x, pix_y, line_end, frame_end,
    input  pix_ready
  );

  modport slave (
    input  pix_valid, pix_data, pix_x, pix_y, line_end, frame_end,
    output pix_ready
  );
endinterface

// File: rtl/screen_scanout.sv
// Captures the rasterizer coverage bitmap on load and streams it out
// row-major, one pixel per accepted transfer, with line/frame end markers.
module screen_scanout #(
  parameter int width  = 4,
  parameter int height = 3,
  parameter int XW     = (width  > 1) ? $clog2(width)  : 1,
  parameter int YW     = (height > 1) ? $clog2(height) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [width*height-1:0]   screen,
  input  logic                      load,
  output logic                      busy,
  output logic                      frame_done,
  output logic [7:0]                drop_count,
  screen_scanout_if.master          pix
);

  localparam int N  = width * height;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, SCAN} state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    frame_q, frame_d;
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;
  logic            done_q, done_d;
  logic [7:0]      drop_q, drop_d;

  logic            scan, x_last, y_last, xfer, fin;
  logic [IW-1:0]   idx;

  always_comb begin
    scan   = (state_q == SCAN);
    x_last = (x_q == XW'(width - 1));
    y_last = (y_q == YW'(height - 1));
    xfer   = scan && pix.pix_ready;
    fin    = xfer && x_last && y_last;
    idx    = IW'(int'(y_q) * width + int'(x_q));

    state_d = state_q;
    frame_d = frame_q;
    x_d     = x_q;
    y_d     = y_q;
    done_d  = 1'b0;
    drop_d  = drop_q;

    case (state_q)
      IDLE: begin
        if (load) begin
          frame_d = screen;
          x_d     = '0;
          y_d     = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (xfer) begin
          if (x_last) begin
            x_d = '0;
            y_d = y_q + YW'(1);
          end else begin
            x_d = x_q + XW'(1);
          end
        end
        // A load coinciding with the final transfer chains straight into the next frame.
        if (fin) begin
          done_d = 1'b1;
          x_d    = '0;
          y_d    = '0;
          if (load) frame_d = screen;
          else      state_d = IDLE;
        end else if (load && drop_q != 8'hFF) begin
          drop_d = drop_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      frame_q <= '0;
      x_q     <= '0;
      y_q     <= '0;
      done_q  <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      x_q     <= x_d;
      y_q     <= y_d;
      done_q  <= done_d;
      drop_q  <= drop_d;
    end
  end

  // Pixel outputs are gated to zero outside SCAN so idle looks like reset.
  assign busy          = scan;
  assign pix.pix_valid = scan;
  assign pix.pix_data  = scan & frame_q[idx];
  assign pix.pix_x     = x_q;
  assign pix.pix_y     = y_q;
  assign pix.line_end  = scan & x_last;
  assign pix.frame_end = scan & x_last & y_last;
  assign frame_done    = done_q;
  assign drop_count    = drop_q;

endmodule

// File: tb/tb_screen_scanout.sv
// Bench for screen_scanout: directed table, corner sequences and random
// traffic checked against a queue-based model of the pixel stream.
module tb_screen_scanout;
  localparam int W = 4;
  localparam int H = 3;
  localparam int N = W * H;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         load = 1'b0;
  logic [N-1:0] screen = '0;
  logic         busy, frame_done;
  logic [7:0]   drop_count;

  screen_scanout_if #(.XW(2), .YW(2)) pix ();

  screen_scanout #(.width(W), .height(H), .XW(2), .YW(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .screen     (screen),
    .load       (load),
    .busy       (busy),
    .frame_done (frame_done),
    .drop_count (drop_count),
    .pix        (pix)
  );

  always #5 clk = ~clk;

  initial pix.pix_ready = 1'b0;

  int nvec = 0;
  int nmis = 0;
  int xfers = 0;

  // Model: an accepted load queues the whole frame; each transfer pops one pixel.
  typedef struct packed {
    logic       d;
    logic [1:0] x;
    logic [1:0] y;
    logic       le;
    logic       fe;
  } mpix_t;

  mpix_t mq[$];
  int    m_drops = 0;
  logic  m_done = 1'b0;

  function automatic void m_fill(input logic [N-1:0] s);
    for (int k = 0; k < N; k++) begin
      mpix_t p;
      p.d  = s[k];
      p.x  = 2'(k % W);
      p.y  = 2'(k / W);
      p.le = ((k % W) == W - 1);
      p.fe = (k == N - 1);
      mq.push_back(p);
    end
  endfunction

  function automatic void model_step(input logic r, input logic l, input logic rd,
                                     input logic [N-1:0] s);
    logic last;
    if (r) begin
      mq.delete();
      m_drops = 0;
      m_done  = 1'b0;
    end else begin
      m_done = 1'b0;
      if (mq.size() == 0) begin
        if (l) m_fill(s);
      end else begin
        last = rd && (mq.size() == 1);
        if (rd) void'(mq.pop_front());
        if (last) begin
          m_done = 1'b1;
          if (l) m_fill(s);
        end else if (l && m_drops < 255) begin
          m_drops++;
        end
      end
    end
  endfunction

  function automatic logic [17:0] m_out();
    if (mq.size() != 0)
      return {2'b11, mq[0].d, mq[0].x, mq[0].y, mq[0].le, mq[0].fe, m_done, 8'(m_drops)};
    return {9'b0, m_done, 8'(m_drops)};
  endfunction

  function automatic logic [17:0] dut_out();
    return {busy, pix.pix_valid, pix.pix_data, pix.pix_x, pix.pix_y,
            pix.line_end, pix.frame_end, frame_done, drop_count};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic l, input logic rd,
                      input logic [N-1:0] s, input string nm);
    reset = r;
    load  = l;
    pix.pix_ready = rd;
    screen = s;
    if (pix.pix_valid && rd && !r) xfers++;
    @(posedge clk);
    model_step(r, l, rd, s);
    #1;
    check(nm, 32'(dut_out()), 32'(m_out()));
    @(negedge clk);
  endtask

  typedef struct {
    logic         rst;
    logic         ld;
    logic         rd;
    logic [N-1:0] scr;
    logic [17:0]  exp;
  } vec_t;

  vec_t tbl[15];
  int   pd[12] = '{0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 1, 0};

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] s;
    logic         found;
    logic         seen_done;
    int           bp[4] = '{1, 0, 0, 1};

    s = 12'b0110_0110_0000;
    tbl[0] = '{1'b1, 1'b0, 1'b0, 12'd0, 18'd0};
    for (int k = 0; k < 12; k++)
      tbl[1 + k] = '{1'b0, (k == 0), 1'b1, s,
                     {2'b11, 1'(pd[k]), 2'(k % 4), 2'(k / 4), (k % 4 == 3), (k == 11),
                      1'b0, 8'd0}};
    tbl[13] = '{1'b0, 1'b0, 1'b1, s, {9'b0, 1'b1, 8'd0}};
    tbl[14] = '{1'b0, 1'b0, 1'b1, s, 18'd0};

    // Directed frame with hand-derived expectations
    for (int i = 0; i < 15; i++) begin
      step(tbl[i].rst, tbl[i].ld, tbl[i].rd, tbl[i].scr, "table_model");
      check("table_vec", 32'(dut_out()), 32'(tbl[i].exp));
    end

    // Backpressure with 1,0,0,1 ready pattern and noisy screen input
    step(1'b1, 1'b0, 1'b0, '0, "bp_reset");
    step(1'b0, 1'b1, 1'b1, 12'hA5C, "bp_load");
    xfers = 0;
    seen_done = 1'b0;
    for (int i = 0; i < 60 && !seen_done; i++) begin
      step(1'b0, 1'b0, 1'(bp[i % 4]), 12'($urandom), "bp_stream");
      seen_done = frame_done;
    end
    check("bp_done_seen", 32'(seen_done), 32'd1);
    check("bp_xfers", 32'(xfers), 32'd12);

    // Seamless reload on the frame_end transfer
    step(1'b1, 1'b0, 1'b0, '0, "sr_reset");
    step(1'b0, 1'b1, 1'b1, 12'h3C7, "sr_load");
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (pix.frame_end) found = 1'b1;
      else step(1'b0, 1'b0, 1'b1, 12'h000, "sr_stream");
    end
    check("sr_frame_end_seen", 32'(found), 32'd1);
    step(1'b0, 1'b1, 1'b1, 12'hE19, "sr_reload");
    check("sr_valid", 32'(pix.pix_valid), 32'd1);
    check("sr_xy", 32'({pix.pix_x, pix.pix_y}), 32'd0);
    check("sr_done", 32'(frame_done), 32'd1);
    check("sr_data", 32'(pix.pix_data), 32'd1);
    check("sr_drop", 32'(drop_count), 32'd0);
    for (int i = 0; i < 14; i++) step(1'b0, 1'b0, 1'b1, 12'h000, "sr_frame2");

    // Rejected loads mid-frame, then saturation
    step(1'b1, 1'b0, 1'b0, '0, "rj_reset");
    step(1'b0, 1'b1, 1'b1, 12'h9B6, "rj_load");
    for (int j = 0; j < 13; j++)
      step(1'b0, (j == 2 || j == 5 || j == 7), 1'b1, 12'($urandom), "rj_stream");
    check("rj_drop3", 32'(drop_count), 32'd3);
    step(1'b0, 1'b1, 1'b0, 12'hFFF, "rj_load2");
    for (int i = 0; i < 300; i++) step(1'b0, 1'b1, 1'b0, 12'($urandom), "rj_sat");
    check("rj_drop255", 32'(drop_count), 32'd255);
    check("rj_hold_xy", 32'({pix.pix_x, pix.pix_y}), 32'd0);

    // Reset mid-frame after 5 transfers
    step(1'b1, 1'b0, 1'b0, '0, "mr_reset0");
    step(1'b0, 1'b1, 1'b1, 12'hFFF, "mr_load");
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 12'hFFF, "mr_stream");
    step(1'b1, 1'b0, 1'b1, 12'hFFF, "mr_reset");
    check("mr_outputs_zero", 32'(dut_out()), 32'd0);
    step(1'b0, 1'b0, 1'b1, 12'hFFF, "mr_idle");
    check("mr_no_done", 32'(frame_done), 32'd0);
    step(1'b0, 1'b1, 1'b1, 12'hFFF, "mr_reload");
    check("mr_restart", 32'({pix.pix_valid, pix.pix_x, pix.pix_y}), 32'h10);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++)
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 7) == 0),
           1'($urandom_range(0, 1)), 12'($urandom), "random");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/screen_scanout.md
# screen_scanout

Downstream stage of the simple rasterizer. Captures the flat `width*height` coverage bitmap (`screen`) on a load strobe and streams it out one pixel per accepted transfer, row-major, over a valid/ready handshake, marking line and frame ends. This decouples the combinational rasterizer output from a slower serial display or pixel sink.

## Interface

- `width`, default 4, pixels per row; bit index of pixel (x, y) in `screen` is `y*width + x`.
- `height`, default 3, number of rows.
- `XW`, default `$clog2(width)` (minimum 1), width of `pix_x`.
- `YW`, default `$clog2(height)` (minimum 1), width of `pix_y`.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `screen`  in  `width*height`  bitmap from the rasterizer; sampled only on an accepted load.
- `load`  in  1  request to capture `screen` and start a frame.
- `busy`  out  1  high while a frame is being streamed.
- `pix_valid`  out  1  pixel outputs valid.
- `pix_ready`  in  1  sink accepts the pixel when high with `pix_valid`.
- `pix_data`  out  1  coverage bit of the current pixel.
- `pix_x`  out  `XW`  column of the current pixel.
- `pix_y`  out  `YW`  row of the current pixel.
- `line_end`  out  1  current pixel is the last in its row (`pix_x == width-1`).
- `frame_end`  out  1  current pixel is the last in the frame (last column and last row).
- `frame_done`  out  1  one-cycle pulse after the final pixel of a frame transfers.
- `drop_count`  out  8  saturating count of rejected loads.

## Operation

- Internal state: frame register (`width*height` bits), x/y counters, FSM {IDLE, SCAN}.
- IDLE: `busy=0`, `pix_valid=0`. On `load=1`, latch `screen` into the frame register, clear x and y to 0, and go to SCAN.
- SCAN: `busy=1`, `pix_valid=1`. `pix_data = frame[y*width+x]`. `line_end` and `frame_end` are decoded from the counters.
- Transfer = `pix_valid && pix_ready`. On a transfer:
  - if `x < width-1`, increment x;
  - else clear x to 0 and increment y;
  - on the `frame_end` transfer, the frame is complete.
- Frame complete with `load=0`: go to IDLE, clear the counters, and pulse `frame_done` in the next cycle.
- Frame complete with `load=1` in the same cycle (seamless reload): latch the new `screen`, clear the counters, stay in SCAN, and still pulse `frame_done`. `pix_valid` does not drop.
- Load during SCAN outside a `frame_end` transfer: rejected. The frame register is unchanged and `drop_count` increments, saturating at 255.
- With no transfer (`pix_ready=0`), every pixel output holds stable and the counters do not move.
- The frame register changes only on an accepted load. Changes on `screen` mid-frame have no effect.
- `reset` has priority over all other inputs. In any state it forces IDLE, clears the frame register and counters, and aborts any frame in progress with no `frame_done` pulse.
- `width==1`: every pixel asserts `line_end`. `height==1`: the last pixel of row 0 asserts `frame_end`.

## Timing

- Reset values: `busy=0`, `pix_valid=0`, `pix_data=0`, `pix_x=0`, `pix_y=0`, `line_end=0`, `frame_end=0`, `frame_done=0`, `drop_count=0`.
- Load accepted in cycle N: `pix_valid=1` with pixel (0,0) in cycle N+1.
- With `pix_ready` held high, one pixel transfers per cycle. A full frame takes `width*height` cycles. For the defaults, the last pixel (3,2) is at cycle N+12 and `frame_done` pulses at N+13.
- `frame_done` is high for exactly one cycle, in the cycle after the `frame_end` transfer.
- All outputs are registered or decoded from registers only. There is no combinational path from `pix_ready` or `load` to any output.

## Test plan

- Reset, then `load=1` with `screen=12'b0110_0110_0000` and `pix_ready=1`:
  - 12 transfers in the order (0,0)…(3,2);
  - `pix_data` sequence 0,0,0,0,0,1,1,0,0,1,1,0;
  - `line_end` high at x=3;
  - `frame_end` only on (3,2);
  - `frame_done` pulses one cycle after (3,2);
  - then `busy=0`.
- Backpressure: toggle `pix_ready` 1,0,0,1,… during a frame. Outputs hold while stalled, there are no skipped or duplicated pixels, and 12 transfers total.
- Seamless reload: assert `load` with a new `screen` in the `frame_end` transfer cycle. Pixel (0,0) of the new frame appears in the next cycle, `pix_valid` never drops, `frame_done` pulses once, and `drop_count` is unchanged.
- Rejected loads: assert `load` on 3 non-final cycles mid-frame and change `screen` each time. The output frame is unchanged and `drop_count=3`. Force 300 rejected loads: `drop_count` stays at 255.
- Reset mid-frame after 5 transfers: the next cycle shows all outputs at their reset values and no `frame_done`. A subsequent load restarts at (0,0).
